// File: rtl/aes_pkg.sv
`default_nettype none
// ============================================================================
// Package  : aes_pkg
// Purpose  : Shared AES-256 constants: widths, round count, S-box table,
//            round-constant table and the S-box lookup function.
// Revision : 1.0 - initial release
// ============================================================================
package aes_pkg;

  localparam int STATE_W = 128;
  localparam int KEY_W   = 256;
  localparam int WORD_W  = 32;

  // Last round index; the round counter wraps back to 0 after this value.
  localparam logic [3:0] NR = 4'd14;

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  // Index 0 is unused so that Rcon[i] lines up with the AES numbering.
  localparam logic [7:0] RCON [8] = '{
    8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40
  };

  function automatic logic [7:0] sbox(input logic [7:0] x);
    return SBOX[x];
  endfunction

endpackage
`default_nettype wire

// File: rtl/add_round_key_sched_key_word_gen.sv
`default_nettype none
// ============================================================================
// Module   : key_word_gen
// Purpose  : Combinational AES-256 key-expansion step. From the two most
//            recent round keys and the round index it produces the next four
//            schedule words (the round key two rounds ahead).
// Revision : 1.0 - initial release
// ============================================================================
module key_word_gen
  import aes_pkg::*;
(
  input  logic [STATE_W-1:0] rk_cur,
  input  logic [STATE_W-1:0] rk_next,
  input  logic [3:0]         rnd,
  output logic [STATE_W-1:0] rk_gen
);

  logic [WORD_W-1:0] last_word;
  logic [WORD_W-1:0] sub_in;
  logic [WORD_W-1:0] sub_out;
  logic [WORD_W-1:0] t_word;
  logic [WORD_W-1:0] n0, n1, n2, n3;
  logic [2:0]        rcon_idx;

  // Word 3 of the newer round key is the schedule's most recent word.
  assign last_word = rk_next[WORD_W-1:0];

  // (rnd+2)/2 == rnd/2 + 1; wraps harmlessly for the unused rnd 14.
  assign rcon_idx = rnd[3:1] + 3'd1;

  // Even rounds rotate before substitution, odd rounds substitute only.
  assign sub_in = rnd[0] ? last_word : {last_word[23:0], last_word[31:24]};

  // The block's only four S-box lookups.
  for (genvar b = 0; b < 4; b++) begin : g_sbox
    assign sub_out[8*b +: 8] = sbox(sub_in[8*b +: 8]);
  end

  assign t_word = rnd[0] ? sub_out : (sub_out ^ {RCON[rcon_idx], 24'h0});

  // Ripple each new word off the word eight positions earlier.
  assign n0 = rk_cur[127:96] ^ t_word;
  assign n1 = rk_cur[95:64]  ^ n0;
  assign n2 = rk_cur[63:32]  ^ n1;
  assign n3 = rk_cur[31:0]   ^ n2;

  assign rk_gen = {n0, n1, n2, n3};

endmodule
`default_nettype wire

// File: rtl/add_round_key_sched.sv
`default_nettype none
// ============================================================================
// Module   : add_round_key_sched
// Purpose  : Registered AddRoundKey stage with on-the-fly AES-256 key
//            expansion. Each accepted state is XORed with the current round
//            key; the schedule then advances and rewinds after round 14 so
//            consecutive blocks reuse one loaded key.
// Revision : 1.0 - initial release
// ============================================================================
module add_round_key_sched
  import aes_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               key_load,
  input  logic [KEY_W-1:0]   key_in,
  input  logic               s_valid,
  output logic               s_ready,
  input  logic [STATE_W-1:0] s_data,
  output logic               m_valid,
  input  logic               m_ready,
  output logic [STATE_W-1:0] m_data,
  output logic [3:0]         m_round,
  output logic               m_last,
  output logic               key_ok
);

  logic [KEY_W-1:0]   key_reg_q, key_reg_d;
  logic [STATE_W-1:0] rk_cur_q,  rk_cur_d;
  logic [STATE_W-1:0] rk_next_q, rk_next_d;
  logic [3:0]         rnd_q,     rnd_d;
  logic               key_ok_q,  key_ok_d;
  logic               m_valid_q, m_valid_d;
  logic [STATE_W-1:0] m_data_q,  m_data_d;
  logic [3:0]         m_round_q, m_round_d;
  logic               m_last_q,  m_last_d;

  logic               accept;
  logic [STATE_W-1:0] rk_gen;

  // A key load takes priority over any pending state in the same cycle.
  assign s_ready = key_ok_q && !key_load && (!m_valid_q || m_ready);
  assign accept  = s_valid && s_ready;

  key_word_gen u_key_word_gen (
    .rk_cur  (rk_cur_q),
    .rk_next (rk_next_q),
    .rnd     (rnd_q),
    .rk_gen  (rk_gen)
  );

  // Next-state logic for the key window, round counter and output register.
  always_comb begin
    key_reg_d = key_reg_q;
    rk_cur_d  = rk_cur_q;
    rk_next_d = rk_next_q;
    rnd_d     = rnd_q;
    key_ok_d  = key_ok_q;
    m_valid_d = m_valid_q;
    m_data_d  = m_data_q;
    m_round_d = m_round_q;
    m_last_d  = m_last_q;

    if (key_load) begin
      key_reg_d = key_in;
      rk_cur_d  = key_in[255:128];
      rk_next_d = key_in[127:0];
      rnd_d     = 4'd0;
      key_ok_d  = 1'b1;
    end else if (accept) begin
      if (rnd_q == NR) begin
        rnd_d     = 4'd0;
        rk_cur_d  = key_reg_q[255:128];
        rk_next_d = key_reg_q[127:0];
      end else begin
        rk_cur_d  = rk_next_q;
        rk_next_d = rk_gen;
        rnd_d     = rnd_q + 4'd1;
      end
    end

    // Output register: load on accept, otherwise drain when downstream takes it.
    if (accept) begin
      m_valid_d = 1'b1;
      m_data_d  = s_data ^ rk_cur_q;
      m_round_d = rnd_q;
      m_last_d  = (rnd_q == NR);
    end else if (m_ready) begin
      m_valid_d = 1'b0;
    end
  end

  // State registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_reg_q <= '0;
      rk_cur_q  <= '0;
      rk_next_q <= '0;
      rnd_q     <= '0;
      key_ok_q  <= 1'b0;
      m_valid_q <= 1'b0;
      m_data_q  <= '0;
      m_round_q <= '0;
      m_last_q  <= 1'b0;
    end else begin
      key_reg_q <= key_reg_d;
      rk_cur_q  <= rk_cur_d;
      rk_next_q <= rk_next_d;
      rnd_q     <= rnd_d;
      key_ok_q  <= key_ok_d;
      m_valid_q <= m_valid_d;
      m_data_q  <= m_data_d;
      m_round_q <= m_round_d;
      m_last_q  <= m_last_d;
    end
  end

  assign m_valid = m_valid_q;
  assign m_data  = m_data_q;
  assign m_round = m_round_q;
  assign m_last  = m_last_q;
  assign key_ok  = key_ok_q;

endmodule
`default_nettype wire

// File: tb/tb_add_round_key_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_add_round_key_sched
// Purpose  : Self-checking bench for add_round_key_sched. The reference model
//            expands the whole AES-256 key into a table of 15 round keys and
//            tracks the handshake at transaction level.
// Revision : 1.0 - initial release
// ============================================================================
module tb_add_round_key_sched;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         key_load;
  logic [255:0] key_in;
  logic         s_valid;
  logic         s_ready;
  logic [127:0] s_data;
  logic         m_valid;
  logic         m_ready;
  logic [127:0] m_data;
  logic [3:0]   m_round;
  logic         m_last;
  logic         key_ok;

  int n_checks = 0;
  int n_pass   = 0;

  localparam logic [255:0] FIPS_KEY =
    256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;

  add_round_key_sched dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .key_load (key_load),
    .key_in   (key_in),
    .s_valid  (s_valid),
    .s_ready  (s_ready),
    .s_data   (s_data),
    .m_valid  (m_valid),
    .m_ready  (m_ready),
    .m_data   (m_data),
    .m_round  (m_round),
    .m_last   (m_last),
    .key_ok   (key_ok)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  logic [7:0]   sb_tab [256];
  logic [127:0] rk_tab [15];
  logic         mdl_key_ok;
  logic         mdl_mv;
  logic [127:0] mdl_md;
  int           mdl_round;
  int           mdl_rnd;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
    logic [7:0] p, a, b;
    p = 8'h00; a = a_in; b = b_in;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = xtime(a);
      b = b >> 1;
    end
    return p;
  endfunction

  // S-box from first principles: GF(2^8) inverse followed by the affine map.
  function automatic logic [7:0] calc_sbox(input logic [7:0] x);
    logic [7:0] inv, s;
    inv = 8'h00;
    if (x != 8'h00)
      for (int c = 1; c < 256; c++)
        if (gmul(x, 8'(c)) == 8'h01) inv = 8'(c);
    for (int i = 0; i < 8; i++)
      s[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8] ^ inv[(i+6)%8] ^ inv[(i+7)%8];
    return s ^ 8'h63;
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sb_tab[w[31:24]], sb_tab[w[23:16]], sb_tab[w[15:8]], sb_tab[w[7:0]]};
  endfunction

  function automatic void expand_key(input logic [255:0] k);
    logic [31:0] w [60];
    logic [31:0] t;
    logic [7:0]  rc;
    for (int i = 0; i < 8; i++) w[i] = k[255-32*i -: 32];
    rc = 8'h01;
    for (int i = 8; i < 60; i++) begin
      t = w[i-1];
      if (i % 8 == 0) begin
        t  = sub_word({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = xtime(rc);
      end else if (i % 8 == 4) begin
        t = sub_word(t);
      end
      w[i] = w[i-8] ^ t;
    end
    for (int r = 0; r < 15; r++) rk_tab[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endfunction

  function automatic logic model_ready();
    return mdl_key_ok && !key_load && (!mdl_mv || m_ready);
  endfunction

  function automatic void model_reset();
    mdl_key_ok = 1'b0; mdl_mv = 1'b0; mdl_md = '0; mdl_round = 0; mdl_rnd = 0;
  endfunction

  // Advance one clock with the current inputs and update the model; no checks.
  task automatic step();
    logic acc;
    acc = s_valid && model_ready();
    @(posedge clk);
    if (key_load) begin
      expand_key(key_in);
      mdl_rnd    = 0;
      mdl_key_ok = 1'b1;
    end
    if (acc) begin
      mdl_md    = s_data ^ rk_tab[mdl_rnd];
      mdl_round = mdl_rnd;
      mdl_mv    = 1'b1;
      mdl_rnd   = (mdl_rnd == 14) ? 0 : mdl_rnd + 1;
    end else if (m_ready) begin
      mdl_mv = 1'b0;
    end
    #1;
  endtask

  function automatic logic [127:0] rand128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // ---------------- tests ----------------
  task automatic test_reset();
    m_ready = 1'b1; s_valid = 1'b1; #1;
    n_checks++; if (m_valid !== 1'b0) $display("FAIL reset_m_valid got %0b want 0", m_valid); else n_pass++;
    n_checks++; if (s_ready !== 1'b0) $display("FAIL reset_s_ready got %0b want 0", s_ready); else n_pass++;
    n_checks++; if (m_data !== 128'h0) $display("FAIL reset_m_data got %h want 0", m_data); else n_pass++;
    n_checks++; if (m_round !== 4'd0) $display("FAIL reset_m_round got %0d want 0", m_round); else n_pass++;
    n_checks++; if (m_last !== 1'b0) $display("FAIL reset_m_last got %0b want 0", m_last); else n_pass++;
    n_checks++; if (key_ok !== 1'b0) $display("FAIL reset_key_ok got %0b want 0", key_ok); else n_pass++;
    step();
    n_checks++; if (m_valid !== 1'b0) $display("FAIL nokey_no_accept got %0b want 0", m_valid); else n_pass++;
    s_valid = 1'b0;
  endtask

  task automatic test_key_load();
    key_in = FIPS_KEY; key_load = 1'b1; m_ready = 1'b1;
    step();
    key_load = 1'b0; #1;
    n_checks++; if (key_ok !== 1'b1) $display("FAIL key_ok got %0b want 1", key_ok); else n_pass++;
    n_checks++; if (s_ready !== 1'b1) $display("FAIL key_s_ready got %0b want 1", s_ready); else n_pass++;
  endtask

  task automatic test_fips_schedule();
    s_valid = 1'b1; m_ready = 1'b1;
    s_data  = 128'h00112233445566778899aabbccddeeff;
    step();
    n_checks++; if (m_data !== 128'h00102030405060708090a0b0c0d0e0f0)
      $display("FAIL round0_data got %h want 00102030405060708090a0b0c0d0e0f0", m_data); else n_pass++;
    n_checks++; if (m_round !== 4'd0) $display("FAIL round0_idx got %0d want 0", m_round); else n_pass++;
    s_data = '0;
    for (int b = 1; b <= 16; b++) begin
      step();
      n_checks++; if (m_valid !== 1'b1 || m_data !== mdl_md || m_round !== 4'(mdl_round))
        $display("FAIL sched_blk%0d got v=%0b r=%0d %h want v=1 r=%0d %h", b, m_valid, m_round, m_data, mdl_round, mdl_md);
      else n_pass++;
      if (b == 2) begin
        n_checks++; if (m_data !== 128'ha573c29fa176c498a97fce93a572c09c)
          $display("FAIL fips_round2 got %h want a573c29fa176c498a97fce93a572c09c", m_data); else n_pass++;
      end
      if (b == 14) begin
        n_checks++; if (m_data !== 128'h24fc79ccbf0979e9371ac23c6d68de36 || m_last !== 1'b1)
          $display("FAIL fips_round14 got %h last=%0b want 24fc79ccbf0979e9371ac23c6d68de36 last=1", m_data, m_last); else n_pass++;
      end
      if (b == 15) begin
        n_checks++; if (m_round !== 4'd0 || m_last !== 1'b0 || m_data !== 128'h000102030405060708090a0b0c0d0e0f)
          $display("FAIL wrap_round0 got r=%0d last=%0b %h want r=0 last=0 000102030405060708090a0b0c0d0e0f", m_round, m_last, m_data);
        else n_pass++;
      end
    end
    s_valid = 1'b0;
  endtask

  task automatic test_random_stream();
    int bad_rdy, bad_out;
    bad_rdy = 0; bad_out = 0;
    key_in = {rand128(), rand128()}; key_load = 1'b1; step(); key_load = 1'b0;
    for (int c = 0; c < 300; c++) begin
      s_valid  = ($urandom_range(0, 3) != 0);
      m_ready  = ($urandom_range(0, 3) != 0);
      s_data   = rand128();
      key_load = ($urandom_range(0, 39) == 0);
      if (key_load) key_in = {rand128(), rand128()};
      #1;
      if (s_ready !== model_ready()) bad_rdy++;
      step();
      if (m_valid !== mdl_mv) bad_out++;
      else if (mdl_mv && (m_data !== mdl_md || m_round !== 4'(mdl_round) || m_last !== (mdl_round == 14)))
        bad_out++;
    end
    key_load = 1'b0;
    n_checks++; if (bad_rdy != 0) $display("FAIL rand_s_ready mismatching cycles %0d want 0", bad_rdy); else n_pass++;
    n_checks++; if (bad_out != 0) $display("FAIL rand_output mismatching cycles %0d want 0", bad_out); else n_pass++;
  endtask

  task automatic test_backpressure();
    int bad;
    bad = 0;
    s_valid = 1'b1; m_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin s_data = rand128(); step(); end
    m_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      s_data = rand128(); #1;
      n_checks++; if (s_ready !== 1'b0) $display("FAIL bp_s_ready cyc%0d got %0b want 0", c, s_ready); else n_pass++;
      step();
      n_checks++; if (m_valid !== 1'b1 || m_data !== mdl_md || m_round !== 4'(mdl_round))
        $display("FAIL bp_hold cyc%0d got r=%0d %h want r=%0d %h", c, m_round, m_data, mdl_round, mdl_md);
      else n_pass++;
    end
    m_ready = 1'b1;
    for (int c = 0; c < 8; c++) begin
      s_data = rand128(); step();
      if (m_valid !== 1'b1 || m_data !== mdl_md || m_round !== 4'(mdl_round)) bad++;
    end
    n_checks++; if (bad != 0) $display("FAIL bp_release mismatching cycles %0d want 0", bad); else n_pass++;
    s_valid = 1'b0;
  endtask

  task automatic test_key_collision();
    logic [255:0] new_key;
    logic [127:0] sd;
    s_valid = 1'b1; m_ready = 1'b1;
    for (int c = 0; c < 20 && mdl_rnd != 7; c++) begin s_data = rand128(); step(); end
    n_checks++; if (m_round !== 4'd6) $display("FAIL coll_setup got r=%0d want 6", m_round); else n_pass++;
    new_key = {rand128(), rand128()};
    key_in = new_key; key_load = 1'b1; s_data = rand128(); #1;
    n_checks++; if (s_ready !== 1'b0) $display("FAIL coll_s_ready got %0b want 0", s_ready); else n_pass++;
    step();
    key_load = 1'b0;
    n_checks++; if (m_valid !== 1'b0) $display("FAIL coll_no_accept got %0b want 0", m_valid); else n_pass++;
    sd = rand128(); s_data = sd;
    step();
    n_checks++; if (m_round !== 4'd0 || m_data !== (sd ^ new_key[255:128]))
      $display("FAIL coll_new_key got r=%0d %h want r=0 %h", m_round, m_data, sd ^ new_key[255:128]);
    else n_pass++;
    s_valid = 1'b0;
  endtask

  task automatic test_async_reset();
    s_valid = 1'b1; m_ready = 1'b1; s_data = rand128(); step();
    m_ready = 1'b0; s_data = rand128(); step();
    n_checks++; if (m_valid !== 1'b1) $display("FAIL ar_setup got %0b want 1", m_valid); else n_pass++;
    rst_n = 1'b0; #1;
    model_reset();
    n_checks++; if (m_valid !== 1'b0 || key_ok !== 1'b0 || m_data !== 128'h0)
      $display("FAIL ar_clear got v=%0b k=%0b %h want v=0 k=0 0", m_valid, key_ok, m_data);
    else n_pass++;
    #1; rst_n = 1'b1; m_ready = 1'b1;
    for (int c = 0; c < 2; c++) begin
      #1;
      n_checks++; if (s_ready !== 1'b0) $display("FAIL ar_s_ready cyc%0d got %0b want 0", c, s_ready); else n_pass++;
      step();
    end
    key_in = FIPS_KEY; key_load = 1'b1; step(); key_load = 1'b0;
    s_data = 128'hffffffff_00000000_12345678_9abcdef0; step();
    n_checks++; if (m_round !== 4'd0 || m_data !== (s_data ^ FIPS_KEY[255:128]))
      $display("FAIL ar_recover got r=%0d %h want r=0 %h", m_round, m_data, s_data ^ FIPS_KEY[255:128]);
    else n_pass++;
    s_valid = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; key_load = 1'b0; key_in = '0; s_valid = 1'b0; s_data = '0; m_ready = 1'b0;
    model_reset();
    for (int i = 0; i < 256; i++) sb_tab[i] = calc_sbox(8'(i));
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    test_reset();
    test_key_load();
    test_fips_schedule();
    test_random_stream();
    test_backpressure();
    test_key_collision();
    test_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
